mips_io_resp: RTL

//  Bus responder on the mips memory interface (memread/memwrite/adr/writedata) serving a

---
 rtl/mips_io_pkg.sv | 28 ++
 rtl/io_fifo.sv | 59 +++++
 rtl/mips_io_resp.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mips_io_pkg.sv
// mips_io_pkg: register offsets and STATUS bit positions for the mips I/O
// window, plus the decoded write-strobe bundle shared inside mips_io_resp.
package mips_io_pkg;

    localparam logic [3:0] OFF_GPIO_OUT = 4'h0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'h1;
    localparam logic [3:0] OFF_TIMER    = 4'h2;
    localparam logic [3:0] OFF_TCMP     = 4'h3;
    localparam logic [3:0] OFF_STATUS   = 4'h4;
    localparam logic [3:0] OFF_TXDATA   = 4'h5;
    localparam logic [3:0] OFF_PRESCALE = 4'h6;

    localparam int ST_MATCH = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_EMPTY = 2;
    localparam int ST_OVF   = 3;

    // One-hot write strobes, valid only for the cycle of a window write.
    typedef struct packed {
        logic gpio_out;
        logic timer;
        logic tcmp;
        logic status;
        logic txdata;
        logic prescale;
    } io_wr_t;

endpackage

// File: rtl/io_fifo.sv
// io_fifo: byte FIFO with registered storage and a show-ahead head.
//   push/wdata/full : producer side; a push while full is dropped unless a
//                     pop happens in the same cycle
//   pop/rdata/valid : consumer side; rdata is the head, pop ignored when empty
//   empty           : no entries
//   clk, reset      : rising-edge clock, asynchronous active-low reset
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             valid,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign valid   = !empty;
    assign rdata   = mem_q[rptr_q[AW-1:0]];
    assign do_pop  = pop && valid;
    // When full, a simultaneous pop frees the slot the push writes into.
    assign do_push = push && (!full || do_pop);

    assign wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    assign rptr_d = rptr_q + {{AW{1'b0}}, do_pop};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/mips_io_resp.sv
// mips_io_resp: memory-mapped I/O responder for the mips memory bus.
//   clk, reset            : rising-edge clock, asynchronous active-low reset
//   memread, memwrite     : bus strobes from the core
//   adr, writedata        : byte address and write data
//   io_rdata, io_hit      : registered read data and "last read hit the window"
//   gpio_in, gpio_out     : asynchronous inputs (synchronised), output register
//   out_valid, out_data,
//   out_ready             : TX FIFO head towards a valid/ready consumer
// The top level selects io_rdata over exmem data whenever io_hit is set.
module mips_io_resp
    import mips_io_pkg::*;
#(
    parameter int         WIDTH      = 8,
    parameter logic [3:0] IO_BASE    = 4'hF,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] io_rdata,
    output logic             io_hit,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready
);

    logic             sel;
    logic [3:0]       off;
    logic             rd_hit;
    io_wr_t           wr;

    logic [WIDTH-1:0] gpio_out_q, gpio_out_d;
    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] tcmp_q, tcmp_d;
    logic [WIDTH-1:0] prescale_q, prescale_d;
    logic             match_q, match_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] io_rdata_q, io_rdata_d;
    logic             io_hit_q, io_hit_d;

    logic             tick, match_set;
    logic             fifo_full, fifo_empty, fifo_pop, ovf_set;
    logic [WIDTH-1:0] status, rd_val;

    assign sel    = (adr[WIDTH-1 -: 4] == IO_BASE);
    assign off    = adr[3:0];
    // A combined read+write cycle is treated purely as a write.
    assign rd_hit = memread && !memwrite && sel;

    always_comb begin
        wr = '0;
        if (memwrite && sel) begin
            case (off)
                OFF_GPIO_OUT: wr.gpio_out = 1'b1;
                OFF_TIMER:    wr.timer    = 1'b1;
                OFF_TCMP:     wr.tcmp     = 1'b1;
                OFF_STATUS:   wr.status   = 1'b1;
                OFF_TXDATA:   wr.txdata   = 1'b1;
                OFF_PRESCALE: wr.prescale = 1'b1;
                default:      wr          = '0;
            endcase
        end
    end

    always_comb begin
        gpio_out_d = gpio_out_q;
        tcmp_d     = tcmp_q;
        prescale_d = prescale_q;
        if (wr.gpio_out) gpio_out_d = writedata;
        if (wr.tcmp)     tcmp_d     = writedata;
        if (wr.prescale) prescale_d = writedata;
    end

    // Timer: a TIMER write overrides a coincident tick, so no match either.
    assign tick = (pcnt_q == prescale_q);

    always_comb begin
        count_d   = count_q;
        pcnt_d    = pcnt_q + WIDTH'(1);
        match_set = 1'b0;
        if (wr.timer) begin
            count_d = '0;
            pcnt_d  = '0;
        end else if (tick) begin
            count_d   = count_q + WIDTH'(1);
            pcnt_d    = '0;
            match_set = (count_d == tcmp_q);
        end
    end

    // Sticky flags: a set in the same cycle as the write-1-to-clear wins.
    assign fifo_pop = out_valid && out_ready;
    assign ovf_set  = wr.txdata && fifo_full && !fifo_pop;
    assign match_d  = match_set || (match_q && !(wr.status && writedata[ST_MATCH]));
    assign ovf_d    = ovf_set   || (ovf_q   && !(wr.status && writedata[ST_OVF]));

    always_comb begin
        status           = '0;
        status[ST_MATCH] = match_q;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf_q;
    end

    always_comb begin
        rd_val = '0;
        case (off)
            OFF_GPIO_OUT: rd_val = gpio_out_q;
            OFF_GPIO_IN:  rd_val = sync2_q;
            OFF_TIMER:    rd_val = count_q;
            OFF_TCMP:     rd_val = tcmp_q;
            OFF_STATUS:   rd_val = status;
            OFF_PRESCALE: rd_val = prescale_q;
            default:      rd_val = '0;
        endcase
    end

    assign io_rdata_d = rd_hit ? rd_val : io_rdata_q;
    assign io_hit_d   = rd_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_q <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            count_q    <= '0;
            pcnt_q     <= '0;
            tcmp_q     <= '0;
            prescale_q <= '0;
            match_q    <= 1'b0;
            ovf_q      <= 1'b0;
            io_rdata_q <= '0;
            io_hit_q   <= 1'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= gpio_in;
            sync2_q    <= sync1_q;
            count_q    <= count_d;
            pcnt_q     <= pcnt_d;
            tcmp_q     <= tcmp_d;
            prescale_q <= prescale_d;
            match_q    <= match_d;
            ovf_q      <= ovf_d;
            io_rdata_q <= io_rdata_d;
            io_hit_q   <= io_hit_d;
        end
    end

    io_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr.txdata),
        .wdata (writedata),
        .full  (fifo_full),
        .pop   (fifo_pop),
        .rdata (out_data),
        .valid (out_valid),
        .empty (fifo_empty)
    );

    assign gpio_out = gpio_out_q;
    assign io_rdata = io_rdata_q;
    assign io_hit   = io_hit_q;

endmodule
